// File: rtl/cnu_row_scheduler.sv
// cnu_row_scheduler
// Time-multiplexes one check-node unit across the NUM_ROWS check rows of an
// LDPC parity-check matrix. Each decode iteration issues every row once,
// then waits one cycle for the last registered parity bit and evaluates the
// accumulated syndrome. Decoding stops on convergence, after MAX_ITER
// iterations, or on an abort.
//
// Ports
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   start       : begin a decode (accepted only when idle)
//   abort       : end a decode early (honoured in RUN, DRAIN and CHECK)
//   p_bit       : registered CNU parity bit, valid alongside wr_en
//   cnu_en      : CNU enable, row row_addr presented this cycle
//   row_addr    : row issued to the CNU / message fetch address
//   wr_en       : CNU result valid, write back to wr_addr
//   wr_addr     : row of the valid CNU result (row_addr delayed one cycle)
//   busy        : decode in progress
//   done        : one-cycle pulse at decode end
//   converged   : final syndrome was zero, held until the next start
//   iter_count  : completed iterations, held until the next start
module cnu_row_scheduler #(
  parameter int NUM_ROWS = 4,
  parameter int ROW_AW   = 2,
  parameter int MAX_ITER = 10,
  parameter int ITER_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              p_bit,
  output logic              cnu_en,
  output logic [ROW_AW-1:0] row_addr,
  output logic              wr_en,
  output logic [ROW_AW-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [ITER_W-1:0] iter_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(NUM_ROWS - 1);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  logic [2:0]        state_q,   state_d;
  logic [ROW_AW-1:0] row_q,     row_d;
  logic              wr_en_q,   wr_en_d;
  logic [ROW_AW-1:0] wr_addr_q, wr_addr_d;
  logic              synd_q,    synd_d;
  logic [ITER_W-1:0] iter_q,    iter_d;
  logic              conv_q,    conv_d;
  logic              abort_hit;

  assign abort_hit = abort && ((state_q == S_RUN) || (state_q == S_DRAIN) ||
                               (state_q == S_CHECK));

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    synd_d    = synd_q;
    iter_d    = iter_q;
    conv_d    = conv_q;
    // Write-back trails the issue by one cycle; an abort kills the write
    // that would have followed the aborted issue.
    wr_en_d   = (state_q == S_RUN) && !abort_hit;
    wr_addr_d = row_q;

    if (wr_en_q) begin
      synd_d = synd_q | p_bit;
    end

    case (state_q)
      S_IDLE: begin
        row_d  = '0;
        synd_d = 1'b0;
        // Results of the previous decode stay visible until a new one starts.
        if (start) begin
          state_d = S_RUN;
          iter_d  = '0;
          conv_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (row_q == LAST_ROW) begin
          row_d   = '0;
          state_d = S_DRAIN;
        end else begin
          row_d = row_q + ROW_AW'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // The last parity bit was folded in at the end of DRAIN.
        iter_d = iter_q + ITER_W'(1);
        if (!synd_q) begin
          conv_d  = 1'b1;
          state_d = S_DONE;
        end else if (iter_q + ITER_W'(1) == ITER_MAX) begin
          conv_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          synd_d  = 1'b0;
          row_d   = '0;
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides any CHECK decision and leaves the partial iteration
    // uncounted.
    if (abort_hit) begin
      state_d = S_DONE;
      conv_d  = 1'b0;
      iter_d  = iter_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      synd_q    <= 1'b0;
      iter_q    <= '0;
      conv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      synd_q    <= synd_d;
      iter_q    <= iter_d;
      conv_q    <= conv_d;
    end
  end

  assign cnu_en     = (state_q == S_RUN);
  assign row_addr   = row_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign converged  = conv_q;
  assign iter_count = iter_q;

endmodule

// File: doc/cnu_row_scheduler.md
# cnu_row_scheduler

Sequences one shared CNU instance across the check-node rows of a parity-check matrix for iterative LDPC decoding. Each cycle it issues one row to the CNU, sets the row address for message fetch and result write-back, and ORs the CNU's registered parity bit into a per-iteration syndrome. At the end of each iteration it stops on convergence (all parity checks satisfied), on MAX_ITER, or on an external abort. It sits between the decoder top-level control and the CNU/message-memory datapath.

## Interface

- NUM_ROWS, 4, check-node rows per iteration (≥2)
- ROW_AW, 2, row address width; ceil(log2(NUM_ROWS))
- MAX_ITER, 10, maximum iterations before forced stop (≥1)
- ITER_W, 4, iteration counter width; must hold MAX_ITER
- Clocking: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begins a decode; sampled only in IDLE
- abort  in  1  terminates a decode early; sampled only while busy
- p_bit  in  1  CNU parity output, registered (valid one cycle after `cnu_en`)
- cnu_en  out  1  CNU enable; row `row_addr` is presented this cycle
- row_addr  out  ROW_AW  row being issued to the CNU (message fetch address)
- wr_en  out  1  CNU output `Y` is valid; write back to `wr_addr`
- wr_addr  out  ROW_AW  row whose CNU result is valid (`row_addr` delayed 1)
- busy  out  1  decode in progress (RUN, DRAIN, CHECK and DONE)
- done  out  1  one-cycle pulse at decode end
- converged  out  1  syndrome was zero at end; held until next start
- iter_count  out  ITER_W  completed iterations; held until next start

## Operation

- FSM states: IDLE, RUN, DRAIN, CHECK, DONE.
- **IDLE:**
  - `start`=1 → go to RUN.
  - Clear row, syndrome, `iter_count` and `converged`.
  - `start` is ignored in every other state.
- **RUN:**
  - `cnu_en`=1; `row_addr` = current row, counting 0..NUM_ROWS-1, one row per cycle.
  - After the cycle with row NUM_ROWS-1 → go to DRAIN; the row counter wraps to 0.
- **DRAIN:** `cnu_en`=0 and `wr_en`=1 for the last row, then → CHECK.
- **Write-back and syndrome:**
  - `wr_en`/`wr_addr` are a one-cycle delay of `cnu_en`/`row_addr`.
  - Whenever `wr_en`=1, syndrome |= `p_bit`.
- **CHECK:**
  - `iter_count` increments.
  - If syndrome==0 → `converged`=1, go to DONE.
  - Else if `iter_count`+1 == MAX_ITER → `converged`=0, go to DONE.
  - Else clear the syndrome and go to RUN (row 0).
- **DONE:** `done`=1 for one cycle, then → IDLE.
  - `converged` and `iter_count` hold through IDLE until the next accepted `start`.
- **Abort:**
  - `abort`=1 in RUN, DRAIN or CHECK → next state DONE with `converged`=0.
  - `cnu_en` and `wr_en` drop the following cycle. A pending write is discarded.
  - `iter_count` is not incremented for the partial iteration.
  - `abort` has priority over a simultaneous CHECK decision.
- **Reset:** `rst_n`=0 at any time forces IDLE immediately.
  - All outputs go to 0: `cnu_en`, `wr_en`, `row_addr`, `wr_addr`, `busy`, `done`, `converged`, `iter_count`.
  - Syndrome and row/delay registers are cleared.

## Timing

- Edge 0 samples `start`. RUN occupies cycles 1..NUM_ROWS, DRAIN is NUM_ROWS+1, CHECK is NUM_ROWS+2.
- One iteration takes NUM_ROWS+2 cycles.
- After k iterations, `done` is high in cycle k·(NUM_ROWS+2)+1.
- `wr_en` is high from cycle 2 through NUM_ROWS+1 of each iteration.
- `p_bit` is sampled on the same edges as `wr_en`.
- The last `p_bit` is folded into the syndrome before CHECK evaluates it.
- `busy` rises in cycle 1 and falls the cycle after DONE.
- A back-to-back `start` is accepted in the first IDLE cycle after DONE.

## Test plan

- **Reset values:** `rst_n`=0 → all outputs 0. Release, hold `start`=0 for 5 cycles → outputs stay 0.
- **First-pass convergence (NUM_ROWS=4):** `p_bit`=0 always, pulse `start` →
  - `row_addr` 0,1,2,3 in cycles 1–4;
  - `wr_addr` 0–3 in cycles 2–5;
  - `done` in cycle 7, `converged`=1, `iter_count`=1.
- **Non-convergence:** `p_bit`=1 on row 2 every iteration, MAX_ITER=10 → `done` in cycle 61, `converged`=0, `iter_count`=10.
- **Late convergence:** `p_bit`=1 only on row 3 of iteration 1 (cycle 5) → second iteration runs; `done` in cycle 13, `converged`=1, `iter_count`=2.
- **Abort:** `abort`=1 in cycle 3 → `done` in cycle 4, `converged`=0, `iter_count`=0; `cnu_en`=0 from cycle 4.
- **Reset and ignored start:**
  - `rst_n`=0 in cycle 3 mid-RUN → outputs 0 immediately; no `done` follows.
  - `start` asserted while busy is ignored; `row_addr` sequence is unchanged.
